// File: rtl/cache_types_pkg.sv
// Shared cache-side types: line/beat widths and adaptor FSM state.
// Imported by the cache-to-memory burst adaptor.
package cache_types_pkg;

    localparam int S_LINE   = 256;
    localparam int S_BURST  = 64;
    localparam int S_BEATS  = S_LINE / S_BURST;
    localparam int S_OFFSET = 5;
    localparam int S_CNT    = $clog2(S_BEATS);

    typedef logic [S_LINE-1:0]  line_t;
    typedef logic [S_BURST-1:0] burst_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Cache line <-> fixed-length memory burst adaptor.
// Ports: clk/rst (async, active-low); cache side line_i/line_o,
// address_i, read_i/write_i, resp_o; memory side burst_i/burst_o,
// address_o, read_o/write_o, resp_i (per-beat ack).
module cacheline_burst_adaptor
    import cache_types_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [S_LINE-1:0]  line_i,
    output logic [S_LINE-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [S_BURST-1:0] burst_i,
    output logic [S_BURST-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam logic [S_CNT-1:0] LAST = S_CNT'(S_BEATS - 1);

    adaptor_state_t     state_q;
    adaptor_state_t     state_d;
    logic [S_CNT-1:0]   cnt_q;
    logic [S_LINE-1:0]  wbuf_q;
    logic [S_LINE-1:0]  line_q;
    logic [31:0]        addr_q;
    logic               start;
    logic               beat;

    // Offset bits are cleared in the burst address, never consumed.
    logic unused_offset;
    assign unused_offset = ^address_i[S_OFFSET-1:0];

    assign start = (state_q == IDLE) && (write_i || read_i);
    assign beat  = resp_i && ((state_q == READ) || (state_q == WRITE));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (write_i)
                    state_d = WRITE;
                else if (read_i)
                    state_d = READ;
            end
            READ, WRITE: begin
                if (resp_i && (cnt_q == LAST))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wbuf_q  <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q <= {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
                cnt_q  <= '0;
                if (write_i)
                    wbuf_q <= line_i;
            end
            // Counter wraps to zero on the last beat.
            if (beat)
                cnt_q <= cnt_q + 1'b1;
            // Read line stays separate from the write buffer so the
            // cache still sees the last read line across a writeback.
            if (resp_i && (state_q == READ))
                line_q[cnt_q*S_BURST +: S_BURST] <= burst_i;
        end
    end

    assign burst_o   = wbuf_q[cnt_q*S_BURST +: S_BURST];
    assign line_o    = line_q;
    assign address_o = addr_q;
    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);

endmodule
